cic_integrator_chain: RTL and testbench

Parametrised cascade of `N_STAGES` wrap-around integrators forming the integrator section of a CIC decimator. It sits between the sample source and the decimator/comb section, accepts one input sample per `in_valid` cycle, and sign-extends it into a wider accumulator. Each stage is registered and advances only on valid samples. Per-stage overflow flags are sticky and can be compiled in or out.

---
 rtl/cic_integrator_chain.sv | 120 ++++++++++++
 tb/tb_cic_integrator_chain.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/cic_integrator_chain.sv
// Integrator section of a CIC decimator: N_STAGES pipelined wrap-around accumulators.
// Define CIC_INTEG_OVF_DETECT_EN to build the per-stage sticky overflow flags.
module cic_integrator_chain #(
  parameter int WIDTH_IN  = 8,
  parameter int WIDTH_ACC = 24,
  parameter int N_STAGES  = 3
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  input  logic [WIDTH_IN-1:0]  x,
  input  logic                 clr,
  output logic [WIDTH_ACC-1:0] y,
  output logic                 out_valid,
  output logic [N_STAGES-1:0]  overflow
);

  generate
    if (WIDTH_ACC < WIDTH_IN || N_STAGES < 1) begin : g_bad_params
      $error("cic_integrator_chain: need WIDTH_ACC >= WIDTH_IN and N_STAGES >= 1");
    end
  endgenerate

  logic [WIDTH_ACC-1:0] acc_q    [N_STAGES];
  logic [WIDTH_ACC-1:0] acc_d    [N_STAGES];
  logic [WIDTH_ACC-1:0] addend_s [N_STAGES];
  logic [WIDTH_ACC-1:0] sum_s    [N_STAGES];
  logic [WIDTH_ACC-1:0] x_ext_s;
  logic                 out_valid_q;
  logic                 out_valid_d;

  assign x_ext_s = WIDTH_ACC'($signed(x));

  // Each stage adds the pre-edge value of its predecessor, giving a true pipeline.
  for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign addend_s[k] = x_ext_s;
    end else begin : g_next
      assign addend_s[k] = acc_q[k-1];
    end
    assign sum_s[k] = acc_q[k] + addend_s[k];
  end

  // Next-state for accumulators and output strobe; clr wins over in_valid.
  always_comb begin
    out_valid_d = 1'b0;
    for (int k = 0; k < N_STAGES; k++) begin
      acc_d[k] = acc_q[k];
    end
    if (clr) begin
      for (int k = 0; k < N_STAGES; k++) begin
        acc_d[k] = '0;
      end
      out_valid_d = 1'b0;
    end else if (in_valid) begin
      for (int k = 0; k < N_STAGES; k++) begin
        acc_d[k] = sum_s[k];
      end
      out_valid_d = 1'b1;
    end else begin
      out_valid_d = 1'b0;
    end
  end

  // Accumulator and strobe registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < N_STAGES; k++) begin
        acc_q[k] <= '0;
      end
      out_valid_q <= 1'b0;
    end else begin
      for (int k = 0; k < N_STAGES; k++) begin
        acc_q[k] <= acc_d[k];
      end
      out_valid_q <= out_valid_d;
    end
  end

  assign y         = acc_q[N_STAGES-1];
  assign out_valid = out_valid_q;

`ifdef CIC_INTEG_OVF_DETECT_EN
  logic [N_STAGES-1:0] ovf_s;
  logic [N_STAGES-1:0] ovf_q;
  logic [N_STAGES-1:0] ovf_d;

  // Signed overflow: addends agree in sign but the truncated sum does not.
  for (genvar k = 0; k < N_STAGES; k++) begin : g_ovf
    assign ovf_s[k] = (acc_q[k][WIDTH_ACC-1] == addend_s[k][WIDTH_ACC-1]) &&
                      (sum_s[k][WIDTH_ACC-1] != acc_q[k][WIDTH_ACC-1]);
  end

  // Sticky flag update, cleared together with the accumulators.
  always_comb begin
    ovf_d = ovf_q;
    if (clr) begin
      ovf_d = '0;
    end else if (in_valid) begin
      ovf_d = ovf_q | ovf_s;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Sticky flag register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow = ovf_q;
`else
  assign overflow = '0;
`endif

endmodule

// File: tb/tb_cic_integrator_chain.sv
// Directed-vector bench: a 3-stage 8->24 chain for the main behaviour and a
// 1-stage 8->8 chain for wrap/overflow.
module tb_cic_integrator_chain;

  logic        clk;
  logic        rstn;
  logic        clr;
  logic        in_valid;
  logic [7:0]  x;
  logic [23:0] y;
  logic        out_valid;
  logic [2:0]  overflow;

  logic        in_valid2;
  logic [7:0]  x2;
  logic [7:0]  y2;
  logic        out_valid2;
  logic [0:0]  overflow2;

  int checks;
  int failures;

  cic_integrator_chain #(.WIDTH_IN(8), .WIDTH_ACC(24), .N_STAGES(3)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .x(x), .clr(clr),
    .y(y), .out_valid(out_valid), .overflow(overflow)
  );

  cic_integrator_chain #(.WIDTH_IN(8), .WIDTH_ACC(8), .N_STAGES(1)) dut_wrap (
    .clk(clk), .rstn(rstn), .in_valid(in_valid2), .x(x2), .clr(clr),
    .y(y2), .out_valid(out_valid2), .overflow(overflow2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One clock on the main chain; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic v, input logic [7:0] xv, input logic c);
    in_valid = v;
    x        = xv;
    clr      = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic cyc2(input logic v, input logic [7:0] xv);
    in_valid2 = v;
    x2        = xv;
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
  endtask

  int step_exp[6]  = '{0, 0, 1, 4, 10, 20};
  int step5_exp[6] = '{0, 0, 5, 20, 50, 100};
  int imp_exp[6]   = '{0, 0, 1, 3, 6, 10};
  logic exp_ovf;

  initial begin
    checks = 0; failures = 0;
    rstn = 1'b0; clr = 1'b0; in_valid = 1'b0; x = 8'd0; in_valid2 = 1'b0; x2 = 8'd0;
`ifdef CIC_INTEG_OVF_DETECT_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    #12;
    check("reset_y", 32'(y), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Step response
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 8'd1, 1'b0);
      check($sformatf("step_y%0d", i + 1), 32'(y), 32'(step_exp[i]));
      check($sformatf("step_ov%0d", i + 1), 32'(out_valid), 32'd1);
    end
    check("step_overflow", 32'(overflow), 32'd0);

    // Clear beats a simultaneous sample
    cyc(1'b1, 8'd5, 1'b1);
    check("clr_y", 32'(y), 32'd0);
    check("clr_out_valid", 32'(out_valid), 32'd0);
    check("clr_overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 8'd5, 1'b0);
      check($sformatf("step5_y%0d", i + 1), 32'(y), 32'(step5_exp[i]));
    end
    cyc(1'b0, 8'd7, 1'b0);
    check("idle_hold_y", 32'(y), 32'd100);
    check("idle_out_valid", 32'(out_valid), 32'd0);

    // Impulse
    cyc(1'b0, 8'd0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, (i == 0) ? 8'd1 : 8'd0, 1'b0);
      check($sformatf("imp_y%0d", i + 1), 32'(y), 32'(imp_exp[i]));
    end

    // Gaps freeze the pipeline
    cyc(1'b0, 8'd0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 8'd1, 1'b0);
      check($sformatf("gap_y%0d", i + 1), 32'(y), 32'(step_exp[i]));
      check($sformatf("gap_ov%0d", i + 1), 32'(out_valid), 32'd1);
      cyc(1'b0, 8'd1, 1'b0);
      check($sformatf("gap_hold_y%0d", i + 1), 32'(y), 32'(step_exp[i]));
      check($sformatf("gap_hold_ov%0d", i + 1), 32'(out_valid), 32'd0);
    end

    // Negative input is sign-extended: x=-3 step
    cyc(1'b0, 8'd0, 1'b1);
    cyc(1'b1, 8'hFD, 1'b0);
    cyc(1'b1, 8'hFD, 1'b0);
    cyc(1'b1, 8'hFD, 1'b0);
    check("neg_y3", 32'(y), 32'h00FF_FFFD);
    cyc(1'b1, 8'hFD, 1'b0);
    check("neg_y4", 32'(y), 32'h00FF_FFF4);

    // Async reset between edges
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("arst_y", 32'(y), 32'd0);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_overflow", 32'(overflow), 32'd0);
    cyc(1'b1, 8'd9, 1'b0);
    check("arst_hold_y", 32'(y), 32'd0);
    check("arst_hold_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Wrap and overflow on the 8-bit single-stage chain
    cyc2(1'b1, 8'd100);
    check("wrap_y1", 32'(y2), 32'd100);
    check("wrap_ovf1", 32'(overflow2), 32'd0);
    check("wrap_out_valid", 32'(out_valid2), 32'd1);
    cyc2(1'b1, 8'd100);
    check("wrap_y2", 32'(y2), 32'h0000_00C8);
    check("wrap_ovf2", 32'(overflow2), 32'(exp_ovf));
    for (int i = 0; i < 2; i++) begin
      cyc2(1'b1, 8'd0);
      check($sformatf("wrap_hold_y%0d", i), 32'(y2), 32'h0000_00C8);
      check($sformatf("wrap_sticky%0d", i), 32'(overflow2), 32'(exp_ovf));
    end
    cyc(1'b0, 8'd0, 1'b1);
    check("wrap_clr_y", 32'(y2), 32'd0);
    check("wrap_clr_ovf", 32'(overflow2), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
